// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and widths for the register file
// writeback arbiter and its scoreboard.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;
  typedef logic [NREGS-1:0]  rf_busy_t;

  localparam rf_addr_t ZERO_REG = '0;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, reservation and register
// file write bundle around the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic     p0_valid;
  logic     p0_ready;
  rf_addr_t p0_addr;
  rf_data_t p0_data;

  logic     p1_valid;
  logic     p1_ready;
  rf_addr_t p1_addr;
  rf_data_t p1_data;

  logic     rsv_en;
  rf_addr_t rsv_addr;

  logic     rf_wr_en;
  rf_addr_t rf_address_wr;
  rf_data_t rf_wr_data;
  rf_busy_t busy;
  logic     rsv_err;

  modport master (
    output p0_valid, p0_addr, p0_data,
    output p1_valid, p1_addr, p1_data,
    output rsv_en, rsv_addr,
    input  p0_ready, p1_ready,
    input  rf_wr_en, rf_address_wr, rf_wr_data,
    input  busy, rsv_err
  );

  modport slave (
    input  p0_valid, p0_addr, p0_data,
    input  p1_valid, p1_addr, p1_data,
    input  rsv_en, rsv_addr,
    output p0_ready, p1_ready,
    output rf_wr_en, rf_address_wr, rf_wr_data,
    output busy, rsv_err
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy bit per register for long-latency writes;
// a reservation beats a same-edge commit.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  rf_addr_t set_addr,
  input  logic     clr_en,
  input  rf_addr_t clr_addr,
  output rf_busy_t busy,
  output logic     err
);

  rf_busy_t busy_q, busy_d;
  logic     err_q, err_d;
  logic     set_ok;

  assign set_ok = set_en && (set_addr != ZERO_REG);

  // next busy vector: clear first, then set wins
  always_comb begin
    busy_d = busy_q;
    err_d  = 1'b0;
    if (clr_en)
      busy_d[clr_addr] = 1'b0;
    if (set_ok) begin
      busy_d[set_addr] = 1'b1;
      err_d = busy_q[set_addr] &&
              !(clr_en && clr_addr == set_addr);
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // busy and error pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter with starvation
// guard and registered register-file write port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          gnt0, gnt1, xfer;
  wb_req_t       win;

  logic     wr_en_q, wr_en_d;
  rf_addr_t addr_q, addr_d;
  rf_data_t data_q, data_d;

  rf_busy_t sb_busy;
  logic     sb_err;

  // grant: port 0 by default, port 1 when alone
  // or after too many consecutive losses
  always_comb begin
    gnt1 = rst && bus.p1_valid &&
           (!bus.p0_valid || starve_q == LIMIT);
    gnt0 = rst && bus.p0_valid && !gnt1;
    xfer = gnt0 || gnt1;
    win  = gnt1 ? '{addr: bus.p1_addr, data: bus.p1_data}
                : '{addr: bus.p0_addr, data: bus.p0_data};
  end

  // starvation counter and output stage next state
  always_comb begin
    starve_d = starve_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (gnt1)
      starve_d = '0;
    else if (bus.p1_valid && gnt0 && starve_q != LIMIT)
      starve_d = starve_q + 1'b1;
    if (xfer) begin
      wr_en_d = (win.addr != ZERO_REG);
      addr_d  = win.addr;
      data_d  = win.data;
    end
  end

  // counter and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  wb_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.rsv_en),
    .set_addr (bus.rsv_addr),
    .clr_en   (gnt1),
    .clr_addr (bus.p1_addr),
    .busy     (sb_busy),
    .err      (sb_err)
  );

  assign bus.p0_ready      = gnt0;
  assign bus.p1_ready      = gnt1;
  assign bus.rf_wr_en      = wr_en_q;
  assign bus.rf_address_wr = addr_q;
  assign bus.rf_wr_data    = data_q;
  assign bus.busy          = sb_busy;
  assign bus.rsv_err       = sb_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench with a cycle model of the
// arbiter compared on every falling edge.
module tb_regfile_wb_arbiter;

  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.p0_valid = 0; bus.p0_addr = 0; bus.p0_data = 0;
    bus.p1_valid = 0; bus.p1_addr = 0; bus.p1_data = 0;
    bus.rsv_en = 0; bus.rsv_addr = 0;
  endtask

  // model: what the block must do, stated as rules
  int          m_losses;
  logic        m_wr_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  logic        m_err;

  function automatic logic want1();
    return rst && bus.p1_valid &&
           (!bus.p0_valid || m_losses >= LIM);
  endfunction

  function automatic logic want0();
    return rst && bus.p0_valid && !want1();
  endfunction

  function automatic logic [31:0] busy_after();
    logic [31:0] b;
    b = m_busy;
    if (want1()) b[bus.p1_addr] = 1'b0;
    if (bus.rsv_en && bus.rsv_addr != 0)
      b[bus.rsv_addr] = 1'b1;
    return b;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_losses <= 0; m_wr_en <= 0; m_addr <= 0;
      m_data <= 0; m_busy <= 0; m_err <= 0;
    end else begin
      m_err <= bus.rsv_en && bus.rsv_addr != 0 &&
               m_busy[bus.rsv_addr] &&
               !(want1() && bus.p1_addr == bus.rsv_addr);
      m_busy <= busy_after();
      if (want1()) m_losses <= 0;
      else if (bus.p1_valid && bus.p0_valid)
        m_losses <= (m_losses + 1 > LIM) ? LIM : m_losses + 1;
      if (want1()) begin
        m_wr_en <= bus.p1_addr != 0;
        m_addr <= bus.p1_addr; m_data <= bus.p1_data;
      end else if (want0()) begin
        m_wr_en <= bus.p0_addr != 0;
        m_addr <= bus.p0_addr; m_data <= bus.p0_data;
      end else m_wr_en <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m_p0_ready", bus.p0_ready, want0());
      chk("m_p1_ready", bus.p1_ready, want1());
      chk("m_wr_en", bus.rf_wr_en, m_wr_en);
      chk("m_addr", bus.rf_address_wr, m_addr);
      chk("m_data", bus.rf_wr_data, m_data);
      chk("m_busy", bus.busy, m_busy);
      chk("m_err", bus.rsv_err, m_err);
    end
  end

  // mixed traffic: p0v p0a p0d p1v p1a p1d rsv rsva
  logic [31:0] tv [12][8] = '{
    '{1, 1, 32'h11, 0, 0, 0, 1, 12},
    '{1, 2, 32'h22, 1, 12, 32'hC0, 1, 13},
    '{1, 3, 32'h33, 1, 12, 32'hC0, 0, 0},
    '{0, 0, 0, 1, 12, 32'hC0, 1, 12},
    '{0, 0, 0, 1, 13, 32'hD0, 0, 0},
    '{1, 0, 32'h44, 1, 14, 32'hE0, 1, 13},
    '{1, 4, 32'h55, 1, 14, 32'hE0, 0, 0},
    '{1, 4, 32'h55, 1, 14, 32'hE0, 1, 0},
    '{1, 5, 32'h66, 1, 14, 32'hE0, 0, 0},
    '{1, 6, 32'h77, 1, 14, 32'hE0, 0, 0},
    '{1, 7, 32'h88, 1, 14, 32'hE0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0}
  };

  int win_c;

  initial begin
    idle();
    // reset with toggling inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.p0_valid = i[0]; bus.p0_addr = 5'(i + 1);
      bus.p1_valid = ~i[0]; bus.p1_addr = 5'(i + 2);
      bus.rsv_en = 1; bus.rsv_addr = 5'(i + 3);
      #1;
      chk("rst_wr_en", bus.rf_wr_en, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_p0_ready", bus.p0_ready, 0);
    end
    chk("rst_addr", bus.rf_address_wr, 0);
    chk("rst_data", bus.rf_wr_data, 0);
    chk("rst_err", bus.rsv_err, 0);
    idle();
    tick();
    rst = 1;

    // first port-0 write
    tick();
    bus.p0_valid = 1; bus.p0_addr = 3;
    bus.p0_data = 32'hDEADBEEF;
    #1 chk("first_p0_ready", bus.p0_ready, 1);
    tick();
    idle();
    chk("first_wr_en", bus.rf_wr_en, 1);
    chk("first_addr", bus.rf_address_wr, 3);
    chk("first_data", bus.rf_wr_data, 32'hDEADBEEF);

    // starvation guard
    bus.p0_valid = 1; bus.p0_addr = 4; bus.p0_data = 32'hA0;
    bus.p1_valid = 1; bus.p1_addr = 7; bus.p1_data = 32'h55;
    win_c = 0;
    for (int c = 1; c <= 10 && win_c == 0; c++) begin
      #1;
      if (bus.p1_ready) begin
        win_c = c;
        chk("starve_p0_stall", bus.p0_ready, 0);
      end
      tick();
    end
    chk("starve_win_cycle", win_c, 5);
    chk("starve_addr", bus.rf_address_wr, 7);
    chk("starve_data", bus.rf_wr_data, 32'h55);
    #1 chk("starve_cleared", bus.p1_ready, 0);
    tick();
    idle();

    // port-1 write to zero register
    bus.p1_valid = 1; bus.p1_data = 32'h1234;
    #1 chk("zero_p1_ready", bus.p1_ready, 1);
    tick();
    idle();
    chk("zero_wr_en", bus.rf_wr_en, 0);
    chk("zero_busy", bus.busy, 0);

    // reserve and commit register 9
    bus.rsv_en = 1; bus.rsv_addr = 9;
    tick();
    idle();
    chk("rsv9_busy", bus.busy[9], 1);
    bus.p1_valid = 1; bus.p1_addr = 9; bus.p1_data = 32'h99;
    tick();
    idle();
    chk("commit9_busy", bus.busy[9], 0);
    chk("commit9_wr_en", bus.rf_wr_en, 1);
    chk("commit9_addr", bus.rf_address_wr, 9);

    // set beats same-edge clear, then double reserve
    bus.rsv_en = 1; bus.rsv_addr = 9;
    tick();
    bus.p1_valid = 1; bus.p1_addr = 9; bus.p1_data = 32'h9A;
    tick();
    idle();
    chk("setwin_busy", bus.busy[9], 1);
    chk("setwin_err", bus.rsv_err, 0);
    bus.rsv_en = 1; bus.rsv_addr = 9;
    tick();
    idle();
    chk("dup_err", bus.rsv_err, 1);
    tick();
    chk("dup_err_drop", bus.rsv_err, 0);

    // async reset mid-cycle
    bus.rsv_en = 1; bus.rsv_addr = 10;
    tick();
    idle();
    bus.p0_valid = 1; bus.p0_addr = 5; bus.p0_data = 1;
    tick();
    idle();
    chk("pre_rst_busy", bus.busy, 32'h0000_0600);
    chk("pre_rst_wr_en", bus.rf_wr_en, 1);
    #2 rst = 0;
    #1;
    chk("async_wr_en", bus.rf_wr_en, 0);
    chk("async_busy", bus.busy, 0);
    tick();
    rst = 1;

    // mixed traffic against the model
    for (int v = 0; v < 12; v++) begin
      bus.p0_valid = tv[v][0][0];
      bus.p0_addr = tv[v][1][4:0];
      bus.p0_data = tv[v][2];
      bus.p1_valid = tv[v][3][0];
      bus.p1_addr = tv[v][4][4:0];
      bus.p1_data = tv[v][5];
      bus.rsv_en = tv[v][6][0];
      bus.rsv_addr = tv[v][7][4:0];
      tick();
    end
    idle();
    tick();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
  - Port 0: in-order pipeline writeback.
  - Port 1: long-latency unit (load/MDU).
- Registers the selected write before driving the register file write port.
- Keeps a per-register busy scoreboard for long-latency destinations, so issue logic can stall on RAW/WAW hazards.
- Sits between the writeback stage / load unit and register_file write inputs (address_wr, wr_data, wr_en).

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W.
- STARVE_LIMIT, 4, consecutive port-1 losses before port 1 is forced to win; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_valid  in  1  pipeline writeback request.
- p0_ready  out  1  port-0 accept (combinational).
- p0_addr  in  ADDR_W  destination register, port 0.
- p0_data  in  DATA_W  write data, port 0.
- p1_valid  in  1  long-latency writeback request.
- p1_ready  out  1  port-1 accept (combinational).
- p1_addr  in  ADDR_W  destination register, port 1.
- p1_data  in  DATA_W  write data, port 1.
- rsv_en  in  1  reserve a destination for a long-latency op at issue.
- rsv_addr  in  ADDR_W  register to reserve.
- rf_wr_en  out  1  register file write enable (registered).
- rf_address_wr  out  ADDR_W  register file write address (registered).
- rf_wr_data  out  DATA_W  register file write data (registered).
- busy  out  NREGS  scoreboard; bit i = register i has a pending long-latency write.
- rsv_err  out  1  one-cycle registered pulse on an illegal reservation.

Behaviour:
- Reset (rst=0, async): rf_wr_en=0, rf_address_wr=0, rf_wr_data=0, busy=0, rsv_err=0, starve_cnt=0.
- Transfer on a port = valid & ready in the same cycle. A ready is never asserted without its valid.
- Grant, combinational:
  - Only one valid: that port is granted.
  - Both valid: port 1 if starve_cnt==STARVE_LIMIT, else port 0.
  - Neither valid: no grant.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - +1 (saturating at STARVE_LIMIT) when p1_valid and port 0 is granted.
  - Cleared to 0 on any port-1 transfer.
  - Held otherwise.
- Output stage latency = 1 cycle:
  - On a transfer at edge N: rf_address_wr and rf_wr_data take the winner's addr/data; rf_wr_en = (addr != 0).
  - Writes to $zero are accepted but suppressed.
  - No transfer: rf_wr_en=0; rf_address_wr and rf_wr_data hold their previous values.
- Throughput: one write per cycle; the losing requester must hold valid/addr/data stable until accepted.
- Scoreboard:
  - Set: rsv_en & rsv_addr!=0 sets busy[rsv_addr] at the edge.
  - Clear: a port-1 transfer clears busy[p1_addr] at the same edge rf_wr_en is registered. busy falls in the cycle the write appears on the port.
  - Port-0 transfers never touch busy.
  - rsv_addr==0 is ignored.
- Simultaneous set and clear of the same register: set wins, busy stays 1 (a new op reserved it).
- Illegal reservation: rsv_en to a nonzero register already busy and not being cleared this edge.
  - busy stays 1; rsv_err pulses high for one cycle after the edge.
  - Issue logic must stall on busy, so this is an error condition only.
- Port-1 commit to a non-busy register: write proceeds; busy is unchanged (0).
- Reset mid-operation: the pending output write is discarded (rf_wr_en=0) and all reservations are lost.

Decomposition:
- Package regfile_pkg:
  - ADDR_W, DATA_W, NREGS, ZERO_REG=0.
  - Typedef wb_req_t {addr, data}.
  - Typedef rf_addr_t.
- One sub-module: wb_scoreboard, holding the busy vector.
  - Inputs: set_en/set_addr, clr_en/clr_addr.
  - Outputs: busy, err.
  - Owns the set-over-clear and zero-register rules.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset with inputs toggling -> all outputs 0. After release, p0_valid=1, addr=3, data=0xDEADBEEF -> p0_ready=1 same cycle; next cycle rf_wr_en=1, rf_address_wr=3, rf_wr_data=0xDEADBEEF.
- Port 0 held valid every cycle, port 1 held valid (addr=7, data=0x55) -> port 1 loses 4 cycles, wins cycle 5 (starve_cnt=4). Port 0 stalls (p0_ready=0) exactly that cycle; starve_cnt returns to 0.
- p1 write to addr 0 with data 0x1234 -> p1_ready=1, next cycle rf_wr_en=0; busy unchanged.
- rsv_en addr=9 -> busy[9]=1 next cycle. Later p1 transfer addr=9 -> busy[9]=0 in the same cycle rf_wr_en=1, rf_address_wr=9.
- Same edge: p1 commit addr=9 and rsv_en addr=9 -> busy[9] stays 1, rsv_err=0. Then rsv_en addr=9 again with no commit -> rsv_err=1 for exactly one cycle.
- Assert rst=0 asynchronously mid-cycle while a write is registered and busy=0x0000_0600 -> rf_wr_en and busy drop to 0 immediately, without waiting for a clock edge.
